mem_responder: RTL
==================

# mem_responder

Word-addressed data memory that acts as the responder side of the CPU's memory-request interface. It accepts one read or write request at a time, models a fixed multi-cycle access latency with an internal counter and state machine, and signals completion with a one-cycle acknowledge. It sits beside the CPU as the backing store for load/store traffic, and later for a cache's refill and writeback traffic.

## Interface
- DATA_WIDTH, 32, width of one memory word and of the data ports
- DEPTH, 256, number of words; power of two, at least 2
- LATENCY, 10, cycles from request capture to acknowledge; at least 1
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  reset; asynchronous, active-high
- req_i  input  1  request valid; sampled only in IDLE
- we_i  input  1  1 = write, 0 = read; captured with req_i
- addr_i  input  32  byte address; word index = addr_i[log2(DEPTH)+1:2]
- data_i  input  DATA_WIDTH  write data; captured with req_i
- ack_o  output  1  access complete; high for exactly one cycle per request
- data_o  output  DATA_WIDTH  read data; valid while ack_o is high and held until the next read completes
- busy_o  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, WAIT, ACK.
- IDLE
  - If req_i=1 at an edge, capture the word index, we_i and data_i into registers.
  - Load the counter with LATENCY-1 and go to WAIT.
  - If req_i=0, stay in IDLE.
- WAIT
  - If the counter is nonzero, decrement it and stay in WAIT.
  - If the counter is 0, perform the access and go to ACK on the same edge.
    - Write: mem[idx] <= captured data; data_o unchanged.
    - Read: data_o <= mem[idx].
- ACK
  - ack_o=1 for this cycle only; next state is IDLE unconditionally.
- req_i, we_i, addr_i and data_i are ignored in WAIT and ACK. The requester need not hold them after capture.
- If req_i is still high in the IDLE cycle after ACK, it is a new request. Requesters must drop req_i on the cycle they observe ack_o.
- Address rules
  - addr_i[1:0] is ignored.
  - Bits above log2(DEPTH)+1 are ignored, so addresses alias modulo DEPTH words.
  - There is no error response.
- The memory array is not reset; contents survive rst_i. The bench preloads the array hierarchically.
- Read-after-write to the same index returns the newly written data.

## Timing
- Reset values: state=IDLE, counter=0, ack_o=0, busy_o=0, data_o=0, captured registers=0.
- Reset asserted mid-operation (WAIT or ACK):
  - Returns to IDLE immediately.
  - A pending write is not performed.
  - ack_o drops asynchronously.
  - data_o goes to 0.
- Latency: request sampled at edge n → ack_o high from edge n+LATENCY to edge n+LATENCY+1.
- busy_o is high from edge n to edge n+LATENCY+1, which is LATENCY+1 cycles.
- Minimum spacing between accepted requests is LATENCY+2 edges: the request is sampled at edge n, ACK occupies the cycle after edge n+LATENCY, IDLE is re-entered at edge n+LATENCY+1, and the next request can be sampled at edge n+LATENCY+2.
- LATENCY=1 is legal: WAIT lasts one cycle with the counter already 0.
- All outputs are registered or decoded directly from the state register; there is no combinational path from inputs to outputs.

## Test plan
- Reset check: assert rst_i asynchronously between edges → ack_o=0, busy_o=0, data_o=0 immediately; state stays IDLE with req_i=0.
- Write then read (LATENCY=10):
  - Write 0xDEADBEEF to addr 0x10, sampled at edge 0 → ack_o high only in the cycle after edge 10; data_o unchanged.
  - Read addr 0x10 → data_o=0xDEADBEEF with ack_o, held afterwards.
- Busy ignore: during WAIT, pulse req_i with a write of 0x12345678 to addr 0x20 → no extra ack; a later read of 0x20 returns the preloaded value.
- Back-to-back: hold req_i high through ACK with read of addr 0x4 → second request sampled at edge 12, second ack after edge 22.
- Reset mid-write: write 0xCAFEF00D to addr 0x8, assert rst_i at cycle 5 → no ack; a subsequent read of 0x8 returns the preloaded value.
- Aliasing (DEPTH=256): write 0xA5A5A5A5 to addr 0x403, then read addr 0x000 → data_o=0xA5A5A5A5.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed data memory answering one request at a time after a fixed latency
module mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t                state, state_n;
  logic [CW-1:0]         cnt;
  logic [AW-1:0]         idx;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  access;
  logic                  unused_addr;
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
  assign access = state == WAIT && cnt == '0;
  assign ack_o  = state == ACK;
  assign busy_o = state != IDLE;
  // next state: accept in IDLE, leave WAIT when the countdown expires, ACK lasts one cycle
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (req_i ? WAIT : IDLE) : state == WAIT ? (access ? ACK : WAIT) : IDLE;
  end
  // state, request capture, latency countdown and read data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      we_q   <= 1'b0;
      wd     <= '0;
      data_o <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_i) begin
        cnt  <= CW'(LATENCY - 1);
        idx  <= addr_i[AW+1:2];
        we_q <= we_i;
        wd   <= data_i;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access && !we_q) data_o <= mem[idx];
    end
  end
  // storage array keeps its contents across reset; a write is dropped if reset hits first
  always_ff @(posedge clk_i) begin
    if (access && we_q && !rst_i) mem[idx] <= wd;
  end
endmodule
